// File: rtl/io_pkg.sv
// Shared I/O display constants: hex segment patterns and digit count.
// Patterns are active-low {g,f,e,d,c,b,a}.
package io_pkg;

    localparam int DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex digit to active-low seven-segment pattern.
// Ports: nibble (4-bit value in), seg ({g,f,e,d,c,b,a}, active-low out).
module hex_to_seg7
    import io_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/cout_display.sv
// Output register with 4-digit multiplexed hex seven-segment display.
// Ports: clk, reset (sync, active-high), bus (sampled), cout_read/cout_done
// load handshake, cout_value (LED mirror), an/seg/dp (active-low display).
module cout_display
    import io_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter bit LZ_BLANK    = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       bus,
    input  logic              cout_read,
    output logic              cout_done,
    output logic [15:0]       cout_value,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg,
    output logic              dp
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    logic [15:0]       value_q, value_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;

    logic [3:0] nibble;
    logic [6:0] hex_seg;
    logic       blank;

    assign nibble = value_q[{idx_q, 2'b00} +: 4];

    hex_to_seg7 u_hex (
        .nibble (nibble),
        .seg    (hex_seg)
    );

    // A digit is blanked only when it and every digit to its left are zero.
    always_comb begin
        blank = 1'b0;
        unique case (idx_q)
            2'd0: blank = 1'b0;
            2'd1: blank = (value_q[15:4] == 12'h000);
            2'd2: blank = (value_q[15:8] == 8'h00);
            2'd3: blank = (value_q[15:12] == 4'h0);
        endcase
    end

    always_comb begin
        value_d = value_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        if (cout_read) begin
            value_d = bus[15:0];
            ovf_d   = (bus[31:16] != 16'h0000);
            done_d  = 1'b1;
        end

        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end

        an_d  = ~(DIGITS'(1) << idx_q);
        seg_d = (LZ_BLANK && blank) ? SEG_BLANK : hex_seg;
        dp_d  = ~(ovf_q && (idx_q == 2'd0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            an_q    <= '1;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
        end else begin
            value_q <= value_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign cout_done  = done_q;
    assign cout_value = value_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;

endmodule

// File: tb/tb_cout_display.sv
// Self-checking bench for cout_display with a short refresh period.
// Two instances share stimulus: plain hex and leading-zero blanking.
module tb_cout_display;

    logic        clk;
    logic        reset;
    logic [31:0] bus;
    logic        cout_read;

    logic        done_a, done_b;
    logic [15:0] val_a, val_b;
    logic [3:0]  an_a, an_b;
    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_q [$];

    cout_display #(.REFRESH_DIV(4), .LZ_BLANK(1'b0)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .cout_read  (cout_read),
        .cout_done  (done_a),
        .cout_value (val_a),
        .an         (an_a),
        .seg        (seg_a),
        .dp         (dp_a)
    );

    cout_display #(.REFRESH_DIV(4), .LZ_BLANK(1'b1)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .cout_read  (cout_read),
        .cout_done  (done_b),
        .cout_value (val_b),
        .an         (an_b),
        .seg        (seg_b),
        .dp         (dp_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits (bounded) until instance A lights the requested digit.
    task automatic wait_an(input logic [3:0] target, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (an_a === target) hit = 1'b1;
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL %s timeout an=%b want %b", tag, an_a, target);
        end
    endtask

    task automatic chk_seg(input logic [6:0] got, input logic [6:0] want,
                           input string tag);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s seg=%b want %b", tag, got, want);
        end
    endtask

    task automatic chk_dp(input logic want, input string tag);
        n_checks++;
        if (dp_a !== want) begin
            n_fail++;
            $display("FAIL %s dp=%b want %b", tag, dp_a, want);
        end
    endtask

    // Single-cycle load; checks the acknowledge against the scoreboard.
    task automatic load(input logic [31:0] data);
        logic [15:0] e;
        @(negedge clk);
        bus       = data;
        cout_read = 1'b1;
        exp_q.push_back(data[15:0]);
        @(negedge clk);
        cout_read = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (done_a !== 1'b1 || val_a !== e) begin
            n_fail++;
            $display("FAIL load done=%b val=%h want 1 %h", done_a, val_a, e);
        end
        @(negedge clk);
        n_checks++;
        if (done_a !== 1'b0 || val_a !== e) begin
            n_fail++;
            $display("FAIL ack_pulse done=%b val=%h want 0 %h",
                     done_a, val_a, e);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        cout_read = 1'b0;
        bus       = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (an_a !== 4'b1111 || seg_a !== 7'b1111111 || dp_a !== 1'b1 ||
            done_a !== 1'b0 || val_a !== 16'h0) begin
            n_fail++;
            $display("FAIL reset an=%b seg=%b dp=%b done=%b val=%h",
                     an_a, seg_a, dp_a, done_a, val_a);
        end
        reset = 1'b0;
    endtask

    task automatic test_scan();
        logic [3:0] e_an;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            e_an = ~(4'b0001 << (k / 4));
            n_checks++;
            if (an_a !== e_an || seg_a !== 7'b1000000 || done_a !== 1'b0) begin
                n_fail++;
                $display("FAIL scan k=%0d an=%b seg=%b done=%b want %b",
                         k, an_a, seg_a, done_a, e_an);
            end
        end
    endtask

    task automatic test_beef();
        load(32'h0000_BEEF);
        wait_an(4'b1110, "beef_d0");
        chk_seg(seg_a, 7'b0001110, "beef_d0");
        chk_dp(1'b1, "beef_dp");
        wait_an(4'b1101, "beef_d1");
        chk_seg(seg_a, 7'b0000110, "beef_d1");
        wait_an(4'b1011, "beef_d2");
        chk_seg(seg_a, 7'b0000110, "beef_d2");
        wait_an(4'b0111, "beef_d3");
        chk_seg(seg_a, 7'b0000011, "beef_d3");
    endtask

    task automatic test_overflow();
        load(32'h0001_1234);
        wait_an(4'b1110, "ovf_d0");
        chk_dp(1'b0, "ovf_dp_d0");
        chk_seg(seg_a, 7'b0011001, "ovf_d0");
        wait_an(4'b1101, "ovf_d1");
        chk_dp(1'b1, "ovf_dp_d1");
        chk_seg(seg_a, 7'b0110000, "ovf_d1");
        load(32'h0000_0005);
        wait_an(4'b1110, "clr_d0");
        chk_dp(1'b1, "clr_dp");
        chk_seg(seg_a, 7'b0010010, "clr_d0");
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        @(negedge clk);
        for (int i = 1; i <= 3; i++) begin
            bus       = 32'(i * 'h11);
            cout_read = 1'b1;
            exp_q.push_back(16'(i * 'h11));
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (done_a !== 1'b1 || val_a !== e) begin
                n_fail++;
                $display("FAIL b2b_%0d done=%b val=%h want 1 %h",
                         i, done_a, val_a, e);
            end
        end
        cout_read = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done_a !== 1'b0 || val_a !== 16'h0033) begin
            n_fail++;
            $display("FAIL b2b_end done=%b val=%h want 0 0033", done_a, val_a);
        end
    endtask

    task automatic test_blank();
        load(32'h0000_0040);
        wait_an(4'b1110, "lz_d0");
        chk_seg(seg_b, 7'b1000000, "lz_d0");
        wait_an(4'b1101, "lz_d1");
        chk_seg(seg_b, 7'b0011001, "lz_d1");
        wait_an(4'b1011, "lz_d2");
        chk_seg(seg_b, 7'b1111111, "lz_d2");
        chk_seg(seg_a, 7'b1000000, "nolz_d2");
        wait_an(4'b0111, "lz_d3");
        chk_seg(seg_b, 7'b1111111, "lz_d3");
        n_checks++;
        if (an_b !== 4'b0111) begin
            n_fail++;
            $display("FAIL lz_an an=%b want 0111", an_b);
        end
        load(32'h0000_0000);
        wait_an(4'b1110, "lz0_d0");
        chk_seg(seg_b, 7'b1000000, "lz0_d0");
        wait_an(4'b1101, "lz0_d1");
        chk_seg(seg_b, 7'b1111111, "lz0_d1");
    endtask

    task automatic test_reset_mid_scan();
        load(32'h0000_1234);
        wait_an(4'b1011, "rst_wait");
        bus       = 32'h0000_AAAA;
        cout_read = 1'b1;
        reset     = 1'b1;
        @(negedge clk);
        n_checks++;
        if (val_a !== 16'h0 || an_a !== 4'b1111 || done_a !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid val=%h an=%b done=%b want 0000 1111 0",
                     val_a, an_a, done_a);
        end
        cout_read = 1'b0;
        reset     = 1'b0;
        @(negedge clk);
        n_checks++;
        if (an_a !== 4'b1110 || seg_a !== 7'b1000000 || done_a !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_rel an=%b seg=%b done=%b want 1110 1000000 0",
                     an_a, seg_a, done_a);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_beef();
        test_overflow();
        test_back_to_back();
        test_blank();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cout_display.md
# cout_display

Output stage of the I/O path: consumes a value placed on the shared 32-bit data bus by the control unit and latches it into an output register. It drives a 4-digit multiplexed, active-low seven-segment display in hexadecimal. It returns a one-cycle `cout_done` acknowledge to control and flags values that do not fit in 16 bits via the decimal point.

## Interface
- `REFRESH_DIV`, 100000: clk cycles each digit stays lit; must be ≥ 2.
- `LZ_BLANK`, 0: 1 = blank leading zero digits (digit 0 never blanked).
- `clk`  input  1: system clock.
- `reset`  input  1: reset, synchronous, active-high.
- `bus`  input  32: shared tri0 data bus, sampled only; this block never drives it.
- `cout_read`  input  1: from control; load `bus` into the output register this edge.
- `cout_done`  output  1: one-cycle acknowledge of a load.
- `cout_value`  output  16: current output register, for LED mirror.
- `an`  output  4: digit enables, active-low; `an[0]` = rightmost digit.
- `seg`  output  7: `{g,f,e,d,c,b,a}`, active-low.
- `dp`  output  1: decimal point, active-low.

## Operation
- **Load:** at a rising edge with `cout_read`=1 and `reset`=0:
  - `cout_value` ← `bus[15:0]`.
  - `ovf` ← (`bus[31:16]` ≠ 0).
  - `cout_done` ← 1.
- **Acknowledge:** at every other non-reset edge, `cout_done` ← 0. Back-to-back `cout_read` loads every cycle and holds `cout_done` high on consecutive cycles, one per load.
- **Refresh counter:**
  - `cnt` counts 0..`REFRESH_DIV`-1, width `$clog2(REFRESH_DIV)`.
  - At the wrap, digit index `idx` (2 bits) increments 0→1→2→3→0.
- **Digit select:** nibble k = `cout_value[4k+3:4k]`. Each edge registers:
  - `an` = ~(1<<`idx`)
  - `seg` = decode(nibble `idx`)
  - `dp` = ~(`ovf` && `idx`==0)
- **Hex decode, active-low:**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- **Blanking:** with `LZ_BLANK`=1, digit k≥1 shows `seg`=1111111 when nibbles k..3 are all zero. `an` still scans normally.
- `cout_read` during reset is ignored.

## Timing
- **Reset values:**
  - `cout_value`=0, `ovf`=0, `cout_done`=0
  - `cnt`=0, `idx`=0
  - `an`=1111, `seg`=1111111, `dp`=1
- **First edge after reset release:** `an`=1110, `seg`=1000000 (digit 0 shows "0").
- **Load latency:** `cout_read` sampled at edge N.
  - `cout_value`/`cout_done` change after edge N.
  - Display outputs reflect the new value after edge N+1, for whichever digit is active.
- **Scan:** each digit is active for exactly `REFRESH_DIV` cycles; a full scan takes 4×`REFRESH_DIV` cycles.
- **Load vs. scan:** a load during a scan does not reset `cnt` or `idx`.
- **Reset mid-scan or mid-load:** all state returns to reset values at that edge; a pending `cout_read` in the same cycle is lost.

## Structure
- **Shared package `io_pkg`:**
  - `SEG_BLANK` = 7'b1111111
  - `SEG_HEX[16]` constant array of the patterns above
  - `DIGITS` = 4
- **Sub-module `hex_to_seg7`:** combinational, 4-bit in, 7-bit active-low out, indexes `SEG_HEX`. Reused by later display blocks.
- **Top level:** load register, acknowledge flop, refresh counter, index and output registers.

## Test plan
- Reset, sim with `REFRESH_DIV`=4 → after release, `an` cycles 1110→1101→1011→0111 every 4 clk; `seg`=1000000 throughout; `cout_done`=0.
- Bus=0x0000_BEEF, `cout_read` 1 cycle → `cout_done` high exactly 1 cycle; `cout_value`=BEEF; digits 0..3 show F,E,E,b (0001110,0000110,0000110,0000011); `dp`=1.
- Bus=0x0001_1234 loaded → `cout_value`=1234; `dp`=0 only while `an`=1110; a later load of 0x0000_0005 clears it.
- `cout_read` held 3 cycles with bus 0x11, 0x22, 0x33 → `cout_done` high 3 consecutive cycles; final `cout_value`=0x0033.
- `LZ_BLANK`=1, value 0x0040 → digit 0 shows 0, digit 1 shows 4, digits 2 and 3 show 1111111. Value 0x0000 → only digit 0 lit with "0".
- `reset` asserted mid-scan (`idx`=2) in the same cycle as `cout_read` with bus=0xAAAA → `cout_value`=0, `an`=1111, `cout_done` stays 0.
